// File: rtl/countdown_timer_if.sv
// Command/status bundle for countdown_timer: the controller side drives the
// load/start/stop/ack requests and the timer side returns its BCD value and flags.
interface countdown_timer_if;
  logic       load;
  logic [7:0] load_min;
  logic [7:0] load_sec;
  logic       start;
  logic       stop;
  logic       ack;
  logic [7:0] min;
  logic [7:0] sec;
  logic       running;
  logic       done;
  logic       alarm;
  logic       load_err;

  modport master (
    output load, load_min, load_sec, start, stop, ack,
    input  min, sec, running, done, alarm, load_err
  );

  modport slave (
    input  load, load_min, load_sec, start, stop, ack,
    output min, sec, running, done, alarm, load_err
  );
endinterface

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer with a one-second prescaler and alarm.
// Optional COUNTDOWN_AUTORELOAD_EN: restart from the last valid preset on expiry.
module countdown_timer #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic               clk,
  input  logic               reset,
  countdown_timer_if.slave   bus
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [7:0]    min_q, sec_q, min_n, sec_n;
  logic          running_q, done_q, alarm_q, err_q;
  logic          done_n, err_n;
  logic [15:0]   dec;
  logic          load_ok, nonzero;

`ifdef COUNTDOWN_AUTORELOAD_EN
  logic [15:0]   reload, reload_n;
`endif

  function automatic logic bcd_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
  endfunction

  // One-second decrement of {min,sec} with the borrow rippling up the digits.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [3:0] m1, m0, s1, s0;
    {m1, m0, s1, s0} = v;
    if (s0 != 4'd0) begin
      s0 = s0 - 4'd1;
    end else begin
      s0 = 4'd9;
      if (s1 != 4'd0) begin
        s1 = s1 - 4'd1;
      end else begin
        s1 = 4'd5;
        if (m0 != 4'd0) begin
          m0 = m0 - 4'd1;
        end else begin
          m0 = 4'd9;
          m1 = m1 - 4'd1;
        end
      end
    end
    return {m1, m0, s1, s0};
  endfunction

  assign load_ok = bcd_ok(bus.load_min) && bcd_ok(bus.load_sec);
  assign nonzero = ({min_q, sec_q} != 16'h0000);
  assign dec     = bcd_dec({min_q, sec_q});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      presc     <= '0;
      min_q     <= 8'h00;
      sec_q     <= 8'h00;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      alarm_q   <= 1'b0;
      err_q     <= 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
      reload    <= 16'h0000;
`endif
    end else begin
      state     <= state_n;
      presc     <= presc_n;
      min_q     <= min_n;
      sec_q     <= sec_n;
      running_q <= (state_n == RUN);
      done_q    <= done_n;
      alarm_q   <= (state_n == EXPIRED);
      err_q     <= err_n;
`ifdef COUNTDOWN_AUTORELOAD_EN
      reload    <= reload_n;
`endif
    end
  end

  // Request priority: load > stop > start > ack > tick. A rejected load
  // still owns the cycle, so nothing else moves while load_err pulses.
  always_comb begin
    state_n  = state;
    presc_n  = presc;
    min_n    = min_q;
    sec_n    = sec_q;
    done_n   = 1'b0;
    err_n    = 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
    reload_n = reload;
`endif
    if (bus.load) begin
      if (load_ok) begin
        min_n    = bus.load_min;
        sec_n    = bus.load_sec;
        presc_n  = '0;
        state_n  = IDLE;
`ifdef COUNTDOWN_AUTORELOAD_EN
        reload_n = {bus.load_min, bus.load_sec};
`endif
      end else begin
        err_n = 1'b1;
      end
    end else if (bus.stop && state == RUN) begin
      state_n = PAUSE;
    end else if (bus.start && (state == IDLE || state == PAUSE) && nonzero) begin
      state_n = RUN;
      // Resuming from PAUSE keeps the partial second already counted.
      if (state == IDLE) presc_n = '0;
    end else if (bus.ack && state == EXPIRED) begin
      state_n = IDLE;
    end else if (state == RUN) begin
      if (presc == PRESC_LAST) begin
        presc_n        = '0;
        {min_n, sec_n} = dec;
        if (dec == 16'h0000) begin
          done_n = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
          if (reload != 16'h0000) {min_n, sec_n} = reload;
          else                    state_n = EXPIRED;
`else
          state_n = EXPIRED;
`endif
        end
      end else begin
        presc_n = presc + PW'(1);
      end
    end
  end

  assign bus.min      = min_q;
  assign bus.sec      = sec_q;
  assign bus.running  = running_q;
  assign bus.done     = done_q;
  assign bus.alarm    = alarm_q;
  assign bus.load_err = err_q;

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter TICK_DIV, default 100000000, clk cycles per one-second decrement (minimum 2).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 load  input  1  one-cycle request to preset the timer from load_min/load_sec.
REQ-005 load_min  input  8  BCD minutes preset, [7:4] tens 0-5, [3:0] ones 0-9.
REQ-006 load_sec  input  8  BCD seconds preset, same encoding as load_min.
REQ-007 start  input  1  one-cycle request to begin or resume counting down.
REQ-008 stop  input  1  one-cycle request to pause counting.
REQ-009 ack  input  1  one-cycle alarm acknowledge.
REQ-010 min  output  8  current BCD minutes.
REQ-011 sec  output  8  current BCD seconds.
REQ-012 running  output  1  high while in RUN.
REQ-013 done  output  1  one-cycle pulse on expiry.
REQ-014 alarm  output  1  level, high while in EXPIRED.
REQ-015 load_err  output  1  one-cycle pulse when a load is rejected.

Function
REQ-016 FSM states IDLE, RUN, PAUSE, EXPIRED; all outputs registered.
REQ-017 Valid load (all four digits in range) in any state: min/sec take the preset, preset is also stored in a reload register, prescaler clears, state goes to IDLE, alarm drops.
REQ-018 Invalid load (any ones digit >9 or tens digit >5): min/sec/state unchanged, load_err pulses for one cycle.
REQ-019 Priority within one cycle: load > stop > start > tick decrement.
REQ-020 start in IDLE or PAUSE with value nonzero moves to RUN; start with value 00:00 is ignored.
REQ-021 start from IDLE clears the prescaler; start from PAUSE keeps the prescaler count.
REQ-022 stop in RUN moves to PAUSE with value and prescaler frozen; stop in other states is ignored.
REQ-023 Prescaler counts 0..TICK_DIV-1 only in RUN; its wrap to 0 is the tick; the first decrement occurs exactly TICK_DIV cycles after the start edge.
REQ-024 On each tick, decrement with BCD borrow: sec ones 0->9 borrows sec tens; sec tens 0->5 borrows min ones; min ones 0->9 borrows min tens.
REQ-025 The tick that yields 00:00 enters EXPIRED on the same edge, with done high for exactly that one cycle.
REQ-026 EXPIRED holds 00:00 and alarm high until ack (-> IDLE, value stays 00:00) or a valid load; start and stop are ignored in EXPIRED.
REQ-027 ack outside EXPIRED has no effect.

Reset
REQ-028 Reset asserted: min=8'h00, sec=8'h00, reload register 00:00, prescaler 0, state IDLE, running=0, done=0, alarm=0, load_err=0, immediately and independent of clk.
REQ-029 Reset mid-RUN or mid-EXPIRED discards all state; the first edge after deassertion behaves as from IDLE.

Configuration
REQ-030 Macro COUNTDOWN_AUTORELOAD_EN defined: on expiry with reload register nonzero, done pulses, min/sec load the reload value on the same edge, prescaler clears, state stays RUN, and alarm never asserts.
REQ-031 COUNTDOWN_AUTORELOAD_EN defined with reload register 00:00: expiry behaves as REQ-025/026.
REQ-032 COUNTDOWN_AUTORELOAD_EN undefined: no reload path is implemented; expiry always follows REQ-025/026.

Verification (TICK_DIV=4)
REQ-033 Load 00:03, start -> sec=02 at start+4 cycles, 01 at +8, 00 with done=1 and alarm=1 at +12; ack -> alarm=0, state IDLE.
REQ-034 Load 10:00, start, 1 tick -> min=09, sec=59 (full borrow chain).
REQ-035 Load 00:05, start, stop after 6 cycles, wait 20 cycles, start -> sec=04 held during pause; next decrement 2 cycles after resume.
REQ-036 load_sec=8'h6A -> load_err pulses for 1 cycle, min/sec unchanged; start with value 00:00 -> running stays 0.
REQ-037 Assert load, stop and start in the same cycle while in RUN -> preset loaded, state IDLE, running=0; assert reset mid-RUN -> all outputs 0 asynchronously.
REQ-038 With COUNTDOWN_AUTORELOAD_EN, load 00:02, start -> done pulses every 8 cycles, sec returns to 02, alarm stays 0.
